mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and scheduler for the 16:1 select mux datapath.
- Up to 16 requesters compete for the shared mux output. The block picks one owner and drives the mux's 4-bit select with the owner's index.
- The select is held stable for the owner's whole tenure. The owner is released on `done`, on request drop, or on timeout.
- Sits between requester logic and the mux select input; the mux itself stays purely combinational.

Parameters:
- N, 16, number of requesters; fixed at 16 to match the 4-bit mux select.
- SW, 4, select width; must equal log2(N).
- MAX_HOLD, 8, maximum grant tenure in cycles; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  per-requester request; bit i drives mux input i.
- done  input  1  current owner finished; sampled only in GRANT.
- S  output  4  registered mux select; equals the owner index.
- grant  output  16  registered one-hot grant; all-zero when no owner.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async, immediate, also mid-grant):
  - Outputs: S=0, grant=0, busy=0, timeout=0.
  - Internal: ptr=0, hold counter cnt=0, state=IDLE.
- Registers: all outputs are registers; no combinational path from req or done to any output.
- State IDLE:
  - grant=0, busy=0.
  - If req==0, stay in IDLE.
  - Otherwise, winner = first set bit of req scanning from ptr upward, modulo 16 (ptr, ptr+1, …, 15, 0, …, ptr-1).
  - On the next edge: S<=winner, grant<=(1<<winner), busy<=1, cnt<=1, state<=GRANT.
- Latency: req rising in cycle k gives grant/S valid in cycle k+1.
- State GRANT:
  - S and grant are held constant.
  - cnt increments by 1 each cycle and saturates at 255.
- Release conditions, evaluated each GRANT cycle (any one triggers release):
  - (a) done=1
  - (b) req[S]=0
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD
- On release, next edge:
  - state<=IDLE, grant<=0, busy<=0.
  - ptr<=(S+1) mod 16; owner 15 wraps ptr to 0.
  - S keeps its last value (don't-care for the mux when grant=0).
  - timeout<=1 for exactly one cycle only when (c) fired and neither (a) nor (b) fired in that same cycle.
- Mandatory gap: at least one IDLE cycle between consecutive grants, even to a different requester.
  - Grant throughput for a requester that is always asserting = 1 per (tenure+1) cycles.
- Fairness:
  - With all 16 requesters continuously asserted, grants rotate 0,1,…,15,0.
  - Each requester is served exactly once per 16 grants.
- Boundary cases:
  - done asserted in IDLE: ignored.
  - done and cnt==MAX_HOLD in the same cycle: normal release, timeout=0.
  - Requests changing during GRANT: no effect until the next IDLE arbitration.
  - A single requester: re-granted after each one-cycle gap; ptr still advances past it.
  - MAX_HOLD=1: every tenure lasts exactly 1 cycle.

Test Plan:
- Reset/idle: assert rst mid-grant (owner 5) -> S=0, grant=0, busy=0 the same cycle, without a clock edge. After release with req=0, all outputs stay 0.
- Single grant latency: req=16'h0010 at cycle k -> grant=16'h0010, S=4, busy=1 at cycle k+1. done at k+3 -> grant=0 at k+4, ptr=5.
- Round-robin wrap: req=16'hFFFF held, done pulsed each GRANT cycle -> S sequence 0,1,…,15,0,1 with an IDLE cycle between each.
- Pointer skip: ptr=14, req=16'h8002 -> first grant S=15, next grant S=1 (wraps past 0).
- Timeout: MAX_HOLD=8, req=16'h0001 held, done=0 -> grant lasts exactly 8 cycles, then timeout=1 for one cycle with grant=0. Repeat with done at cnt==8 -> timeout stays 0.
- Request drop: owner 3 drops req[3] at its 2nd GRANT cycle -> grant=0 the next cycle, timeout=0, ptr=4.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin select arbiter.
// The master side drives requests and done; the slave (arbiter) drives the mux select and status.
interface mux_rr_arbiter_if #(
  parameter int N  = 16,
  parameter int SW = 4
);
  logic [N-1:0]  req;
  logic          done;
  logic [SW-1:0] S;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout;

  modport master (output req, done, input S, grant, busy, timeout);
  modport slave  (input req, done, output S, grant, busy, timeout);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a 16:1 mux. The select is held for the whole tenure;
// the owner is released on done, on request drop, or after MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int N        = 16,
  parameter int SW       = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic [SW-1:0] s_q, ptr_q, win_d;
  logic [N-1:0]  grant_q;
  logic          busy_q, timeout_q, win_vld;
  logic [7:0]    cnt_q, cnt_d;
  logic          hold_hit, rel_d;

  // Scan from ptr upward, wrapping; iterate high-to-low so the nearest hit wins.
  always_comb begin
    logic [SW-1:0] idx;
    win_d   = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = ptr_q + SW'(k);
      if (bus.req[idx]) begin
        win_d   = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == 8'(MAX_HOLD));
  assign rel_d    = bus.done || !bus.req[s_q] || hold_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            s_q     <= win_d;
            grant_q <= {{(N-1){1'b0}}, 1'b1} << win_d;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rel_d) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= s_q + SW'(1);
            // Only a pure hold expiry counts as a forced revoke.
            timeout_q <= hold_hit && !bus.done && bus.req[s_q];
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.S       = s_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table, directed corner sequences and random traffic
// against a cycle-level reference model built from the arbitration rules.
module tb_mux_rr_arbiter;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(16), .SW(4)) bus ();
  mux_rr_arbiter_if #(.N(16), .SW(4)) bus1 ();
  assign bus1.req  = bus.req;
  assign bus1.done = bus.done;

  mux_rr_arbiter #(.N(16), .SW(4), .MAX_HOLD(MH)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mux_rr_arbiter #(.N(16), .SW(4), .MAX_HOLD(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int m_owner, m_ptr, m_cnt, m_S;
  bit m_to;
  bit prev1;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  s;
    logic [15:0] g;
    logic        busy;
    logic        to;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {10'b0, bus.S, bus.grant, bus.busy, bus.timeout};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [15:0] g;
    logic [15:0] one;
    one = 16'h1;
    g = (m_owner < 0) ? 16'h0 : (one << m_owner);
    return {10'b0, 4'(m_S), g, (m_owner >= 0), m_to};
  endfunction

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_S = 0; m_to = 0;
  endtask

  task automatic m_tick(input logic [15:0] r, input logic d);
    bit a, b, c, found;
    if (m_owner < 0) begin
      m_to = 0;
      found = 0;
      for (int k = 0; k < 16; k++) begin
        int cand;
        cand = (m_ptr + k) % 16;
        if (!found && r[cand]) begin
          found = 1; m_owner = cand; m_S = cand; m_cnt = 1;
        end
      end
    end else begin
      a = d;
      b = !r[m_owner];
      c = (MH != 0) && (m_cnt == MH);
      if (a || b || c) begin
        m_to = c && !a && !b;
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
      end else begin
        m_to = 0;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input logic d);
    bus.req = r;
    bus.done = d;
    prev1 = bus1.busy;
    @(posedge clk);
    m_tick(r, d);
    #1;
    chk("model", dut_vec(), model_vec());
    if (prev1) chk("mh1_tenure", {31'b0, bus1.busy}, 32'd0);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.done = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset", dut_vec(), 32'd0);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    int n, ng;
    int seq [$];
    logic [15:0] rr;
    logic dd;

    bus.req = '0;
    bus.done = 1'b0;
    m_reset();
    #3;
    do_reset();

    // req, done -> S, grant, busy, timeout
    tbl[0] = '{16'h0010, 1'b0, 4'd4, 16'h0010, 1'b1, 1'b0};
    tbl[1] = '{16'h0010, 1'b0, 4'd4, 16'h0010, 1'b1, 1'b0};
    tbl[2] = '{16'h0010, 1'b1, 4'd4, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 1'b0, 4'd4, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 1'b1, 4'd4, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'h0030, 1'b0, 4'd5, 16'h0020, 1'b1, 1'b0};
    tbl[6] = '{16'h0030, 1'b1, 4'd5, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{16'h0030, 1'b0, 4'd4, 16'h0010, 1'b1, 1'b0};
    tbl[8] = '{16'h0000, 1'b0, 4'd4, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("table[%0d]", i), dut_vec(),
          {10'b0, tbl[i].s, tbl[i].g, tbl[i].busy, tbl[i].to});
    end

    // async reset in the middle of a tenure, no clock edge needed
    do_reset();
    step(16'h0020, 1'b0);
    step(16'h0020, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", dut_vec(), 32'd0);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) step(16'h0000, 1'b0);
    chk("idle_zero", dut_vec(), 32'd0);

    // full rotation with wrap
    do_reset();
    ng = 0;
    for (int i = 0; i < 60 && ng < 18; i++) begin
      step(16'hFFFF, 1'b1);
      if (bus.busy) begin
        seq.push_back(int'(bus.S));
        ng++;
      end
    end
    chk("rr_count", 32'(ng), 32'd18);
    for (int i = 0; i < seq.size(); i++)
      chk($sformatf("rr_S[%0d]", i), 32'(seq[i]), 32'(i % 16));

    // pointer at 14 skips to 15, then wraps past 0 to 1
    do_reset();
    step(16'h2000, 1'b0);
    step(16'h2000, 1'b1);
    step(16'h8002, 1'b0);
    chk("skip_first", {28'b0, bus.S}, 32'd15);
    step(16'h8002, 1'b1);
    step(16'h8002, 1'b0);
    chk("skip_wrap", {28'b0, bus.S}, 32'd1);

    // hold expiry
    do_reset();
    step(16'h0001, 1'b0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step(16'h0001, 1'b0);
      if (bus.busy) n++;
      else break;
    end
    chk("tenure_len", 32'(n), 32'(MH));
    chk("timeout_pulse", {15'b0, bus.grant, bus.timeout}, 32'd1);
    step(16'h0001, 1'b0);
    chk("timeout_clear", {31'b0, bus.timeout}, 32'd0);
    for (int i = 0; i < MH-1; i++) step(16'h0001, 1'b0);
    step(16'h0001, 1'b1);
    chk("done_at_hold", {30'b0, bus.busy, bus.timeout}, 32'd0);

    // owner 3 drops its request in its second grant cycle
    do_reset();
    step(16'h0008, 1'b0);
    step(16'h0008, 1'b0);
    step(16'h0000, 1'b0);
    chk("drop_release", {15'b0, bus.grant, bus.timeout}, 32'd0);
    step(16'h0018, 1'b0);
    chk("drop_ptr", {28'b0, bus.S}, 32'd4);

    // random traffic
    do_reset();
    rr = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 16'($urandom) & 16'($urandom);
      dd = ($urandom_range(0, 5) == 0);
      step(rr, dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
